// File: rtl/vx_barrier_table.sv
// Per-core warp barrier table: tracks NUM_BARRIERS concurrent barriers, releases stalled
// warps on local completion and hands finished local phases of global barriers to the cluster.
module vx_barrier_table #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_CORES    = 4,
  parameter int CORE_ID      = 0,
  parameter int GBAR_ENABLE  = 1,
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int NC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int SZ_W = (NW_W > NC_W) ? NW_W : NC_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_W-1:0]      req_wid,
  input  logic [NB_W-1:0]      req_id,
  input  logic                 req_is_global,
  input  logic [SZ_W-1:0]      req_size_m1,
  input  logic [NUM_WARPS-1:0] active_wmask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic                 gbar_req_valid,
  input  logic                 gbar_req_ready,
  output logic [NB_W-1:0]      gbar_req_id,
  output logic [NC_W-1:0]      gbar_req_size_m1,
  output logic [NC_W-1:0]      gbar_req_core_id,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_W-1:0]      gbar_rsp_id,
  output logic                 err
);

  localparam logic            GBAR_EN   = (GBAR_ENABLE != 0);
  localparam logic [SZ_W:0]   ONE       = (SZ_W+1)'(1);
  localparam logic [NC_W-1:0] CORE_ID_V = NC_W'(CORE_ID);

  logic [NUM_BARRIERS-1:0]                valid_q, valid_d;
  logic [NUM_BARRIERS-1:0]                global_q, global_d;
  logic [NUM_BARRIERS-1:0]                pend_q, pend_d;
  logic [NUM_BARRIERS-1:0][SZ_W-1:0]      size_q, size_d;
  logic [NUM_BARRIERS-1:0][SZ_W-1:0]      count_q, count_d;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] wmask_q, wmask_d;

  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 gbar_valid_q, gbar_valid_d;
  logic [NB_W-1:0]      gbar_id_q, gbar_id_d;
  logic [NC_W-1:0]      gbar_size_q, gbar_size_d;
  logic                 err_q, err_d;

  logic                 arr_fire;
  logic                 req_global;
  logic [NUM_WARPS-1:0] arr_bit;
  logic                 use_global;
  logic [SZ_W-1:0]      use_size;
  logic [SZ_W:0]        new_count;
  logic [NUM_WARPS-1:0] new_mask;
  logic                 do_update;
  logic                 complete;

  // The outbound global request is a single slot, so arrivals stall while it is occupied.
  assign req_ready  = !gbar_valid_q;
  assign arr_fire   = req_valid && req_ready;
  assign req_global = req_is_global && GBAR_EN;
  assign arr_bit    = NUM_WARPS'(1) << req_wid;

  always_comb begin
    valid_d      = valid_q;
    global_d     = global_q;
    pend_d       = pend_q;
    size_d       = size_q;
    count_d      = count_q;
    wmask_d      = wmask_q;
    rel_valid_d  = 1'b0;
    rel_mask_d   = '0;
    gbar_valid_d = gbar_valid_q;
    gbar_id_d    = gbar_id_q;
    gbar_size_d  = gbar_size_q;
    err_d        = err_q;
    use_global   = 1'b0;
    use_size     = '0;
    new_count    = '0;
    new_mask     = '0;
    do_update    = 1'b0;
    complete     = 1'b0;

    if (gbar_valid_q && gbar_req_ready) begin
      gbar_valid_d = 1'b0;
    end

    // Cluster response: release the warps parked on a pending global entry.
    if (GBAR_EN && gbar_rsp_valid) begin
      if (valid_q[gbar_rsp_id] && pend_q[gbar_rsp_id]) begin
        rel_valid_d          = 1'b1;
        rel_mask_d           = wmask_q[gbar_rsp_id];
        valid_d[gbar_rsp_id] = 1'b0;
        global_d[gbar_rsp_id] = 1'b0;
        pend_d[gbar_rsp_id]  = 1'b0;
        size_d[gbar_rsp_id]  = '0;
        count_d[gbar_rsp_id] = '0;
        wmask_d[gbar_rsp_id] = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (arr_fire) begin
      if (valid_q[req_id]) begin
        use_global = global_q[req_id];
        use_size   = size_q[req_id];
        if ((req_global != global_q[req_id]) || (req_size_m1 != size_q[req_id])) begin
          err_d = 1'b1;
        end
        if (pend_q[req_id]) begin
          err_d = 1'b1;
        end else if ((wmask_q[req_id] & arr_bit) != '0) begin
          err_d = 1'b1;
        end else begin
          new_count = {1'b0, count_q[req_id]} + ONE;
          new_mask  = wmask_q[req_id] | arr_bit;
          do_update = 1'b1;
        end
      end else begin
        use_global = req_global;
        use_size   = req_size_m1;
        new_count  = ONE;
        new_mask   = arr_bit;
        do_update  = 1'b1;
      end

      // Local barriers count warps; global ones wait for every active warp of this core.
      if (do_update) begin
        complete = use_global ? (new_mask == active_wmask)
                              : (new_count == ({1'b0, use_size} + ONE));
        valid_d[req_id]  = 1'b1;
        global_d[req_id] = use_global;
        size_d[req_id]   = use_size;
        count_d[req_id]  = new_count[SZ_W-1:0];
        wmask_d[req_id]  = new_mask;
        if (complete && use_global) begin
          pend_d[req_id] = 1'b1;
          gbar_valid_d   = 1'b1;
          gbar_id_d      = req_id;
          gbar_size_d    = use_size[NC_W-1:0];
        end else if (complete) begin
          rel_valid_d      = 1'b1;
          rel_mask_d       = rel_mask_d | new_mask;
          valid_d[req_id]  = 1'b0;
          global_d[req_id] = 1'b0;
          size_d[req_id]   = '0;
          count_d[req_id]  = '0;
          wmask_d[req_id]  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      global_q     <= '0;
      pend_q       <= '0;
      size_q       <= '0;
      count_q      <= '0;
      wmask_q      <= '0;
      rel_valid_q  <= 1'b0;
      rel_mask_q   <= '0;
      gbar_valid_q <= 1'b0;
      gbar_id_q    <= '0;
      gbar_size_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      global_q     <= global_d;
      pend_q       <= pend_d;
      size_q       <= size_d;
      count_q      <= count_d;
      wmask_q      <= wmask_d;
      rel_valid_q  <= rel_valid_d;
      rel_mask_q   <= rel_mask_d;
      gbar_valid_q <= gbar_valid_d;
      gbar_id_q    <= gbar_id_d;
      gbar_size_q  <= gbar_size_d;
      err_q        <= err_d;
    end
  end

  assign release_valid    = rel_valid_q;
  assign release_wmask    = rel_mask_q;
  assign gbar_req_valid   = gbar_valid_q;
  assign gbar_req_id      = gbar_id_q;
  assign gbar_req_size_m1 = gbar_size_q;
  assign gbar_req_core_id = gbar_valid_q ? CORE_ID_V : '0;
  assign err              = err_q;

endmodule

// File: tb/tb_vx_barrier_table.sv
// Scoreboard bench for vx_barrier_table: stimulus pushes expected release/global-request
// events with their due cycle; a negedge monitor pops and compares them as the DUT emits.
module tb_vx_barrier_table;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [1:0] req_id;
  logic       req_is_global;
  logic [1:0] req_size_m1;
  logic [3:0] active_wmask;
  logic       release_valid;
  logic [3:0] release_wmask;
  logic       gbar_req_valid;
  logic       gbar_req_ready;
  logic [1:0] gbar_req_id;
  logic [1:0] gbar_req_size_m1;
  logic [1:0] gbar_req_core_id;
  logic       gbar_rsp_valid;
  logic [1:0] gbar_rsp_id;
  logic       err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prevGbar = 1'b0;

  typedef struct { logic [3:0] mask; int cycle; } relExp_t;
  typedef struct { logic [1:0] id; logic [1:0] size; logic [1:0] core; int cycle; } gbarExp_t;
  relExp_t  relQ[$];
  gbarExp_t gbarQ[$];
  relExp_t  relE;
  gbarExp_t gbarE;

  vx_barrier_table #(
    .NUM_WARPS(4), .NUM_BARRIERS(4), .NUM_CORES(4), .CORE_ID(0), .GBAR_ENABLE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_id(req_id),
    .req_is_global(req_is_global), .req_size_m1(req_size_m1), .active_wmask(active_wmask),
    .release_valid(release_valid), .release_wmask(release_wmask),
    .gbar_req_valid(gbar_req_valid), .gbar_req_ready(gbar_req_ready),
    .gbar_req_id(gbar_req_id), .gbar_req_size_m1(gbar_req_size_m1),
    .gbar_req_core_id(gbar_req_core_id),
    .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every release pulse and every new global request must match the queue head.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevGbar = 1'b0;
    end else begin
      if (release_valid) begin
        if (relQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL release_unexpected: actual wmask=0x%0h expected no release (cycle %0d)",
                   release_wmask, cyc);
        end else begin
          relE = relQ.pop_front();
          checkOutput("release_wmask", 32'(release_wmask), 32'(relE.mask));
          checkOutput("release_cycle", 32'(cyc), 32'(relE.cycle));
        end
      end
      if (gbar_req_valid && !prevGbar) begin
        if (gbarQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL gbar_unexpected: actual id=%0d expected no request (cycle %0d)",
                   gbar_req_id, cyc);
        end else begin
          gbarE = gbarQ.pop_front();
          checkOutput("gbar_id", 32'(gbar_req_id), 32'(gbarE.id));
          checkOutput("gbar_size", 32'(gbar_req_size_m1), 32'(gbarE.size));
          checkOutput("gbar_core", 32'(gbar_req_core_id), 32'(gbarE.core));
          checkOutput("gbar_cycle", 32'(cyc), 32'(gbarE.cycle));
        end
      end
      prevGbar = gbar_req_valid;
    end
  end

  // Called at a negedge; the result registers on the coming posedge and is seen one negedge later.
  task automatic expectRelease(input logic [3:0] mask);
    relQ.push_back('{mask: mask, cycle: cyc + 1});
  endtask

  task automatic expectGbar(input logic [1:0] id, input logic [1:0] size);
    gbarQ.push_back('{id: id, size: size, core: 2'd0, cycle: cyc + 1});
  endtask

  task automatic applyStimulus(input logic [1:0] wid, input logic [1:0] id,
                               input logic glob, input logic [1:0] sizeM1);
    req_valid     = 1'b1;
    req_wid       = wid;
    req_id        = id;
    req_is_global = glob;
    req_size_m1   = sizeM1;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    req_valid      = 1'b0;
    gbar_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseRsp(input logic [1:0] id);
    req_valid      = 1'b0;
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = id;
    @(negedge clk);
    gbar_rsp_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && (relQ.size() != 0 || gbarQ.size() != 0); i++) @(negedge clk);
    checkOutput("drain_release", 32'(relQ.size()), 32'd0);
    checkOutput("drain_gbar", 32'(gbarQ.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_wid        = '0;
    req_id         = '0;
    req_is_global  = 1'b0;
    req_size_m1    = '0;
    active_wmask   = '0;
    gbar_req_ready = 1'b0;
    gbar_rsp_valid = 1'b0;
    gbar_rsp_id    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_release_valid", 32'(release_valid), 32'd0);
    checkOutput("reset_gbar_valid", 32'(gbar_req_valid), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    idleCycle();

    $display("[TB] local barrier, four warps on id 1");
    applyStimulus(2'd0, 2'd1, 1'b0, 2'd3);
    applyStimulus(2'd1, 2'd1, 1'b0, 2'd3);
    applyStimulus(2'd2, 2'd1, 1'b0, 2'd3);
    expectRelease(4'b1111);
    applyStimulus(2'd3, 2'd1, 1'b0, 2'd3);
    idleCycle();

    $display("[TB] single-participant barrier on id 0");
    expectRelease(4'b0100);
    applyStimulus(2'd2, 2'd0, 1'b0, 2'd0);
    idleCycle();

    $display("[TB] global barrier id 2 with held request");
    active_wmask = 4'b0011;
    applyStimulus(2'd0, 2'd2, 1'b1, 2'd3);
    expectGbar(2'd2, 2'd3);
    applyStimulus(2'd1, 2'd2, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("hold_gbar_valid", 32'(gbar_req_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    gbar_req_ready = 1'b1;
    @(negedge clk);
    gbar_req_ready = 1'b0;
    checkOutput("gbar_valid_after_ready", 32'(gbar_req_valid), 32'd0);
    checkOutput("req_ready_after_ready", 32'(req_ready), 32'd1);

    $display("[TB] response and local completion in one cycle");
    applyStimulus(2'd2, 2'd1, 1'b0, 2'd1);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'd2;
    expectRelease(4'b1111);
    applyStimulus(2'd3, 2'd1, 1'b0, 2'd1);
    idleCycle();
    checkOutput("err_clean_so_far", 32'(err), 32'd0);

    $display("[TB] duplicate arrival and stray response");
    applyStimulus(2'd1, 2'd3, 1'b0, 2'd2);
    applyStimulus(2'd1, 2'd3, 1'b0, 2'd2);
    idleCycle();
    checkOutput("err_duplicate", 32'(err), 32'd1);
    applyStimulus(2'd0, 2'd3, 1'b0, 2'd2);
    expectRelease(4'b0111);
    applyStimulus(2'd2, 2'd3, 1'b0, 2'd2);
    idleCycle();
    pulseRsp(2'd0);
    checkOutput("err_sticky", 32'(err), 32'd1);
    waitDrain();

    $display("[TB] reset with partial and pending barriers");
    applyStimulus(2'd0, 2'd1, 1'b0, 2'd3);
    applyStimulus(2'd1, 2'd1, 1'b0, 2'd3);
    active_wmask = 4'b1000;
    expectGbar(2'd2, 2'd2);
    applyStimulus(2'd3, 2'd2, 1'b1, 2'd2);
    idleCycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_release_valid", 32'(release_valid), 32'd0);
    checkOutput("midreset_gbar_valid", 32'(gbar_req_valid), 32'd0);
    checkOutput("midreset_gbar_id", 32'(gbar_req_id), 32'd0);
    checkOutput("midreset_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idleCycle();
    expectRelease(4'b0001);
    applyStimulus(2'd0, 2'd1, 1'b0, 2'd0);
    idleCycle();
    pulseRsp(2'd2);
    checkOutput("err_rsp_after_reset", 32'(err), 32'd1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
